// File: rtl/issue_scheduler_pkg.sv
// Shared constants and types for the dual-issue scheduler: pipe encodings,
// FSM state, and the buffered issue-slot record.
package issue_scheduler_pkg;

   localparam int SCHED_REG_AW = 7;
   localparam int SCHED_INST_W = 64;
   localparam int SCHED_LAT_W  = 3;
   localparam int NUM_SRC      = 6;

   localparam logic PIPE_EVEN = 1'b0;
   localparam logic PIPE_ODD  = 1'b1;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_PAIR   = 2'd1,
      ST_SINGLE = 2'd2
   } sched_state_t;

   // Field widths follow the package constants; the module parameters default to them.
   typedef struct packed {
      logic                    pipe;
      logic [SCHED_REG_AW-1:0] ra;
      logic [SCHED_REG_AW-1:0] rb;
      logic [SCHED_REG_AW-1:0] rc;
      logic [2:0]              src_use;
      logic [SCHED_REG_AW-1:0] rt;
      logic                    wr;
      logic [SCHED_LAT_W-1:0]  lat;
      logic [SCHED_INST_W-1:0] inst;
   } issue_slot_t;

   // A latency of zero would never mark the destination busy, so it counts as one.
   function automatic logic [SCHED_LAT_W-1:0] eff_lat(input logic [SCHED_LAT_W-1:0] lat);
      return (lat == '0) ? SCHED_LAT_W'(1) : lat;
   endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decoder-to-scheduler pair transfer plus the scheduler-to-pipe issue strobes.
interface issue_scheduler_if #(
   parameter int REG_ADDR_WIDTH = 7,
   parameter int INST_W         = 64,
   parameter int LAT_W          = 3
);
   // A pair transfers on any cycle with dec_valid && dec_ready. dec_ready is high
   // exactly while the buffer is empty and never depends on dec_valid; a flush in
   // the same cycle discards the offered pair.
   logic                      dec_valid;
   logic                      dec_ready;
   logic                      s0_vld,     s1_vld;
   logic                      s0_pipe,    s1_pipe;
   logic [REG_ADDR_WIDTH-1:0] s0_ra,      s0_rb,     s0_rc;
   logic [REG_ADDR_WIDTH-1:0] s1_ra,      s1_rb,     s1_rc;
   logic [2:0]                s0_src_use, s1_src_use;
   logic [REG_ADDR_WIDTH-1:0] s0_rt,      s1_rt;
   logic                      s0_wr,      s1_wr;
   logic [LAT_W-1:0]          s0_lat,     s1_lat;
   logic [INST_W-1:0]         s0_inst,    s1_inst;
   logic                      flush;
   logic                      even_issue, odd_issue;
   logic [INST_W-1:0]         even_inst,  odd_inst;

   modport master (
      output dec_valid, s0_vld, s1_vld, s0_pipe, s1_pipe,
             s0_ra, s0_rb, s0_rc, s1_ra, s1_rb, s1_rc,
             s0_src_use, s1_src_use, s0_rt, s1_rt, s0_wr, s1_wr,
             s0_lat, s1_lat, s0_inst, s1_inst, flush,
      input  dec_ready, even_issue, odd_issue, even_inst, odd_inst
   );

   modport slave (
      input  dec_valid, s0_vld, s1_vld, s0_pipe, s1_pipe,
             s0_ra, s0_rb, s0_rc, s1_ra, s1_rb, s1_rc,
             s0_src_use, s1_src_use, s0_rt, s1_rt, s0_wr, s1_wr,
             s0_lat, s1_lat, s0_inst, s1_inst, flush,
      output dec_ready, even_issue, odd_issue, even_inst, odd_inst
   );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register result-latency countdown; a register is busy while its count is nonzero.
module issue_scoreboard
   import issue_scheduler_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = SCHED_REG_AW,
   parameter int LAT_W          = SCHED_LAT_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr [NUM_SRC],
   output logic [NUM_SRC-1:0]        o_busy,
   input  logic                      i_ld0_en,
   input  logic [REG_ADDR_WIDTH-1:0] i_ld0_addr,
   input  logic [LAT_W-1:0]          i_ld0_lat,
   input  logic                      i_ld1_en,
   input  logic [REG_ADDR_WIDTH-1:0] i_ld1_addr,
   input  logic [LAT_W-1:0]          i_ld1_lat
);

   localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

   logic [LAT_W-1:0] r_cnt [NUM_REGS];

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         o_busy[i] = (r_cnt[i_rd_addr[i]] != '0);
      end
   end

   // Loads win over the running decrement on the same register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (i_ld1_en && (i_ld1_addr == REG_ADDR_WIDTH'(r))) begin
               r_cnt[r] <= i_ld1_lat;
            end else if (i_ld0_en && (i_ld0_addr == REG_ADDR_WIDTH'(r))) begin
               r_cnt[r] <= i_ld0_lat;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - LAT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler: 2-slot buffer, EMPTY/PAIR/SINGLE FSM, scoreboard gating.
// Optional ISSUE_STATS_EN adds saturating stall_cnt and dual_cnt outputs.
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = SCHED_REG_AW,
   parameter int INST_W         = SCHED_INST_W,
   parameter int LAT_W          = SCHED_LAT_W
) (
   input  logic             clk,
   input  logic             reset,
   issue_scheduler_if.slave sif,
   output sched_state_t     o_dbg_state
`ifdef ISSUE_STATS_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      dual_cnt
`endif
);

   sched_state_t              r_state;
   issue_slot_t               r_slot0;
   issue_slot_t               r_slot1;
   logic                      r_even_issue;
   logic                      r_odd_issue;
   logic [INST_W-1:0]         r_even_inst;
   logic [INST_W-1:0]         r_odd_inst;

   issue_slot_t               w_in0;
   issue_slot_t               w_in1;
   logic [REG_ADDR_WIDTH-1:0] w_rd_addr [NUM_SRC];
   logic [NUM_SRC-1:0]        w_busy;
   logic                      w_s0_blocked;
   logic                      w_s1_blocked;
   logic                      w_raw;
   logic                      w_waw;
   logic                      w_s0_issue;
   logic                      w_s1_issue;

   always_comb begin
      w_in0         = '0;
      w_in0.pipe    = sif.s0_pipe;
      w_in0.ra      = sif.s0_ra;
      w_in0.rb      = sif.s0_rb;
      w_in0.rc      = sif.s0_rc;
      w_in0.src_use = sif.s0_src_use;
      w_in0.rt      = sif.s0_rt;
      w_in0.wr      = sif.s0_wr;
      w_in0.lat     = sif.s0_lat;
      w_in0.inst    = sif.s0_inst;
      w_in1         = '0;
      w_in1.pipe    = sif.s1_pipe;
      w_in1.ra      = sif.s1_ra;
      w_in1.rb      = sif.s1_rb;
      w_in1.rc      = sif.s1_rc;
      w_in1.src_use = sif.s1_src_use;
      w_in1.rt      = sif.s1_rt;
      w_in1.wr      = sif.s1_wr;
      w_in1.lat     = sif.s1_lat;
      w_in1.inst    = sif.s1_inst;
   end

   assign w_rd_addr[0] = r_slot0.ra;
   assign w_rd_addr[1] = r_slot0.rb;
   assign w_rd_addr[2] = r_slot0.rc;
   assign w_rd_addr[3] = r_slot1.ra;
   assign w_rd_addr[4] = r_slot1.rb;
   assign w_rd_addr[5] = r_slot1.rc;

   // src_use bit order is {ra, rb, rc}.
   assign w_s0_blocked = |(r_slot0.src_use & {w_busy[0], w_busy[1], w_busy[2]});
   assign w_s1_blocked = |(r_slot1.src_use & {w_busy[3], w_busy[4], w_busy[5]});

   assign w_raw = r_slot0.wr &&
                  ((r_slot1.src_use[2] && (r_slot1.ra == r_slot0.rt)) ||
                   (r_slot1.src_use[1] && (r_slot1.rb == r_slot0.rt)) ||
                   (r_slot1.src_use[0] && (r_slot1.rc == r_slot0.rt)));
   assign w_waw = r_slot0.wr && r_slot1.wr && (r_slot1.rt == r_slot0.rt);

   assign w_s0_issue = (r_state != ST_EMPTY) && !sif.flush && !w_s0_blocked;
   assign w_s1_issue = (r_state == ST_PAIR) && w_s0_issue &&
                       (r_slot1.pipe != r_slot0.pipe) &&
                       !w_raw && !w_waw && !w_s1_blocked;

   issue_scoreboard #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .LAT_W          (LAT_W)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .i_rd_addr  (w_rd_addr),
      .o_busy     (w_busy),
      .i_ld0_en   (w_s0_issue && r_slot0.wr),
      .i_ld0_addr (r_slot0.rt),
      .i_ld0_lat  (eff_lat(r_slot0.lat)),
      .i_ld1_en   (w_s1_issue && r_slot1.wr),
      .i_ld1_addr (r_slot1.rt),
      .i_ld1_lat  (eff_lat(r_slot1.lat))
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_EMPTY;
         r_slot0      <= '0;
         r_slot1      <= '0;
         r_even_issue <= 1'b0;
         r_odd_issue  <= 1'b0;
         r_even_inst  <= '0;
         r_odd_inst   <= '0;
      end else begin
         r_even_issue <= 1'b0;
         r_odd_issue  <= 1'b0;
         if (w_s0_issue) begin
            if (r_slot0.pipe == PIPE_EVEN) begin
               r_even_issue <= 1'b1;
               r_even_inst  <= r_slot0.inst;
            end else begin
               r_odd_issue  <= 1'b1;
               r_odd_inst   <= r_slot0.inst;
            end
         end
         // Younger only issues on the other pipe, so the two strobes never collide.
         if (w_s1_issue) begin
            if (r_slot1.pipe == PIPE_EVEN) begin
               r_even_issue <= 1'b1;
               r_even_inst  <= r_slot1.inst;
            end else begin
               r_odd_issue  <= 1'b1;
               r_odd_inst   <= r_slot1.inst;
            end
         end
         if (sif.flush) begin
            r_state <= ST_EMPTY;
         end else begin
            unique case (r_state)
               ST_EMPTY: begin
                  if (sif.dec_valid) begin
                     if (sif.s0_vld && sif.s1_vld) begin
                        r_slot0 <= w_in0;
                        r_slot1 <= w_in1;
                        r_state <= ST_PAIR;
                     end else if (sif.s0_vld) begin
                        r_slot0 <= w_in0;
                        r_state <= ST_SINGLE;
                     end else if (sif.s1_vld) begin
                        r_slot0 <= w_in1;
                        r_state <= ST_SINGLE;
                     end
                  end
               end
               ST_PAIR: begin
                  if (w_s0_issue) begin
                     if (w_s1_issue) begin
                        r_state <= ST_EMPTY;
                     end else begin
                        r_slot0 <= r_slot1;
                        r_state <= ST_SINGLE;
                     end
                  end
               end
               ST_SINGLE: begin
                  if (w_s0_issue) begin
                     r_state <= ST_EMPTY;
                  end
               end
               default: r_state <= ST_EMPTY;
            endcase
         end
      end
   end

   assign sif.dec_ready  = (r_state == ST_EMPTY);
   assign sif.even_issue = r_even_issue;
   assign sif.odd_issue  = r_odd_issue;
   assign sif.even_inst  = r_even_inst;
   assign sif.odd_inst   = r_odd_inst;
   assign o_dbg_state    = r_state;

`ifdef ISSUE_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_dual_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_dual_cnt  <= '0;
      end else begin
         if ((r_state != ST_EMPTY) && !w_s0_issue && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (w_s1_issue && (r_dual_cnt != '1)) begin
            r_dual_cnt <= r_dual_cnt + 32'd1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign dual_cnt  = r_dual_cnt;
`endif

endmodule
